e_int_narrow: RTL and testbench

E_INT_NARROW -- requirements
Module: e_int_narrow

---
 rtl/e_int_narrow.sv | 103 ++++++++++
 tb/tb_e_int_narrow.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_int_narrow.sv
`timescale 1ns/1ps
// Two-stage pipelined signed integer narrowing with ready/valid flow control.
// Converts IN_W-bit values to OUT_W bits by truncation or saturation and counts overflows.
module e_int_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic              _i_clk,
    input  logic              _i_rst_n,
    input  logic              _i_in_valid,
    input  logic [IN_W-1:0]   _i_in_data,
    input  logic              _i_mode,
    input  logic              _i_out_ready,
    input  logic              _i_clr_count,
    output logic [OUT_W+10:0] __output
);

    localparam logic [7:0]       CNT_MAX = 8'hFF;
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic              r_s1_valid;
    logic [IN_W-1:0]   r_s1_data;
    logic              r_s1_mode;
    logic              r_s2_valid;
    logic [OUT_W-1:0]  r_s2_data;
    logic              r_s2_ovf;
    logic [7:0]        r_ovf_count;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_xfer;
    logic [IN_W-OUT_W:0] w_upper;
    logic              w_fits;
    logic [OUT_W-1:0]  w_conv_data;
    logic              w_conv_ovf;

    assign w_xfer     = r_s2_valid && _i_out_ready;
    assign w_s2_adv   = !r_s2_valid || _i_out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept   = _i_in_valid && w_in_ready;

    // The value fits iff every bit from the output sign bit upward is a copy of it.
    assign w_upper = r_s1_data[IN_W-1:OUT_W-1];
    assign w_fits  = (&w_upper) || !(|w_upper);

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch inferred.
        w_conv_data = r_s1_data[OUT_W-1:0];
        w_conv_ovf  = !w_fits;
        if (r_s1_mode && !w_fits) begin
            w_conv_data = r_s1_data[IN_W-1] ? SAT_NEG : SAT_POS;
        end
    end

    // NOTE: data registers are reset too, so nothing from before reset can leak out later.
    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= _i_in_valid;
            if (w_accept) begin
                r_s1_data <= _i_in_data;
                r_s1_mode <= _i_mode;
            end
        end
    end

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ovf   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_conv_data;
            r_s2_ovf   <= w_conv_ovf;
        end
    end

    // Clear wins over a simultaneous increment; the count sticks at its maximum.
    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            r_ovf_count <= '0;
        end else if (_i_clr_count) begin
            r_ovf_count <= '0;
        end else if (w_xfer && r_s2_ovf && (r_ovf_count != CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign __output = {r_s2_valid,
                       w_in_ready,
                       r_s2_valid ? r_s2_data : {OUT_W{1'b0}},
                       r_s2_valid & r_s2_ovf,
                       r_ovf_count};

endmodule

// File: tb/tb_e_int_narrow.sv
`timescale 1ns/1ps
// Self-checking bench for e_int_narrow: queue-based reference model compared every cycle,
// directed scenarios pinned with literal expectations, plus a randomized stream.
module tb_e_int_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        mode;
    logic        out_ready;
    logic        clr_count;
    logic [18:0] w_out;

    e_int_narrow #(.IN_W(16), .OUT_W(8)) dut (
        ._i_clk       (clk),
        ._i_rst_n     (rst_n),
        ._i_in_valid  (in_valid),
        ._i_in_data   (in_data),
        ._i_mode      (mode),
        ._i_out_ready (out_ready),
        ._i_clr_count (clr_count),
        .__output     (w_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       pres;
    } item_t;

    item_t      q[$];
    logic [8:0] obs[$];
    int         m_cnt;
    logic       last_accept;
    logic       last_in_ready;
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected conversion from plain integer arithmetic on the signed value.
    function automatic void conv(input logic [15:0] d, input logic m,
                                 output logic [7:0] r, output logic o);
        int v;
        v = int'($signed(d));
        o = (v > 127) || (v < -128);
        r = d[7:0];
        if (o && m) r = (v > 127) ? 8'h7F : 8'h80;
    endfunction

    function automatic logic model_presented();
        return (q.size() > 0) && q[0].pres;
    endfunction

    // An item is waiting in the first stage unless the only item is already on the outputs.
    function automatic logic model_in_ready();
        logic pres, s1occ;
        pres  = model_presented();
        s1occ = (q.size() == 2) || (q.size() == 1 && !pres);
        return !s1occ || !pres || out_ready;
    endfunction

    task automatic compare();
        logic       pres;
        logic [7:0] ed;
        logic       eo;
        pres = model_presented();
        ed   = pres ? q[0].data : 8'h00;
        eo   = pres ? q[0].ovf  : 1'b0;
        check("out_valid", 32'(w_out[18]),    32'(pres));
        check("in_ready",  32'(w_out[17]),    32'(model_in_ready()));
        check("out_data",  32'(w_out[16:9]),  32'(ed));
        check("out_ovf",   32'(w_out[8]),     32'(eo));
        check("ovf_count", 32'(w_out[7:0]),   32'(m_cnt));
        last_in_ready = w_out[17];
        if (w_out[18] && out_ready) obs.push_back(w_out[16:8]);
    endtask

    task automatic model_step();
        logic  pres, xfer, s2adv, rdy;
        item_t it;
        pres  = model_presented();
        xfer  = pres && out_ready;
        s2adv = !pres || out_ready;
        rdy   = model_in_ready();
        last_accept = in_valid && rdy;
        if (clr_count) m_cnt = 0;
        else if (xfer && q[0].ovf && m_cnt < 255) m_cnt++;
        if (xfer) void'(q.pop_front());
        if (s2adv && q.size() > 0 && !q[0].pres) begin
            it = q[0];
            it.pres = 1'b1;
            q[0] = it;
        end
        if (last_accept) begin
            conv(in_data, mode, it.data, it.ovf);
            it.pres = 1'b0;
            q.push_back(it);
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] d, input logic o);
        if (idx < obs.size()) check(name, 32'(obs[idx]), 32'({d, o}));
        else check(name, 32'hDEAD, 32'({d, o}));
    endtask

    task automatic reset_pulse();
        #3 rst_n = 1'b0;
        q.delete();
        m_cnt = 0;
        #2 check("rst_async_out", 32'(w_out), 32'h0002_0000);
        #2 rst_n = 1'b1;
    endtask

    logic [15:0] stream[5];
    int          idx;
    logic        saw_low;
    logic [7:0]  rb;

    initial begin
        n_checks = 0; n_fail = 0; m_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
        out_ready = 1'b1; clr_count = 1'b0;
        #5 check("reset_out", 32'(w_out), 32'h0002_0000);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Truncate, in-range values back-to-back
        obs.delete();
        send(16'h0001, 1'b0); send(16'hFFFF, 1'b0); send(16'hFF8A, 1'b0);
        idle(3);
        check("trunc_len", 32'(obs.size()), 32'd3);
        check_log("trunc_0", 0, 8'h01, 1'b0);
        check_log("trunc_1", 1, 8'hFF, 1'b0);
        check_log("trunc_2", 2, 8'h8A, 1'b0);
        check("trunc_cnt", 32'(w_out[7:0]), 32'd0);

        // Truncate with overflow
        obs.delete();
        send(16'h0180, 1'b0); send(16'hFE7F, 1'b0);
        idle(3);
        check_log("tovf_0", 0, 8'h80, 1'b1);
        check_log("tovf_1", 1, 8'h7F, 1'b1);
        check("tovf_cnt", 32'(w_out[7:0]), 32'd2);

        // Saturate
        obs.delete();
        send(16'h0180, 1'b1); send(16'hFE00, 1'b1); send(16'hFF80, 1'b1); send(16'h007F, 1'b1);
        idle(3);
        check_log("sat_0", 0, 8'h7F, 1'b1);
        check_log("sat_1", 1, 8'h80, 1'b1);
        check_log("sat_2", 2, 8'h80, 1'b0);
        check_log("sat_3", 3, 8'h7F, 1'b0);
        check("sat_cnt", 32'(w_out[7:0]), 32'd4);

        // Backpressure: out_ready low for three cycles mid-stream
        obs.delete();
        for (int i = 0; i < 5; i++) stream[i] = 16'(i + 1);
        idx = 0; saw_low = 1'b0; mode = 1'b0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (idx < 5);
            in_data   = (idx < 5) ? stream[idx] : 16'h0;
            cycle();
            if (!last_in_ready) saw_low = 1'b1;
            if (last_accept) idx++;
        end
        out_ready = 1'b1;
        idle(2);
        check("bp_in_ready_dropped", 32'(saw_low), 32'd1);
        check("bp_len", 32'(obs.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_log("bp_item", i, 8'(i + 1), 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 1));
            clr_count = ($urandom_range(0, 63) == 0);
            rb        = 8'($urandom);
            in_data   = ($urandom_range(0, 1) == 0) ? {{8{rb[7]}}, rb} : 16'($urandom);
            cycle();
        end
        clr_count = 1'b0; out_ready = 1'b1;
        idle(3);

        // Counter saturation and clear-overrides-increment
        clr_count = 1'b1; cycle(); clr_count = 1'b0;
        in_valid = 1'b1; in_data = 16'h0180; mode = 1'b0;
        repeat (260) cycle();
        idle(3);
        check("cnt_sat", 32'(w_out[7:0]), 32'd255);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 16'h0180; mode = 1'b0;
            cycle();
            in_valid = 1'b0;
            cycle();
            clr_count = 1'b1;
            cycle();
            clr_count = 1'b0;
            cycle();
            check("cnt_clr_on_xfer", 32'(w_out[7:0]), 32'd0);
        end

        // Reset with two items in flight
        obs.delete();
        out_ready = 1'b0;
        send(16'h0011, 1'b0); send(16'h0022, 1'b0);
        reset_pulse();
        out_ready = 1'b1;
        send(16'h0033, 1'b0);
        idle(4);
        check("rst_len", 32'(obs.size()), 32'd1);
        check_log("rst_new_item", 0, 8'h33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
